// File: rtl/lcd_seg_pkg.sv
// lcd_seg_pkg: shared constants for the LCD/7-segment register file.
//   Word addresses of the control registers, CTRL bit positions, BLINK
//   field ranges and the blank segment pattern.
//   The BLINK register exists only when LCD_SEG_BLINK_EN is defined.
package lcd_seg_pkg;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_PRESCALE = 8'h01;
    localparam logic [7:0] ADDR_STATUS   = 8'h02;
    localparam logic [7:0] ADDR_BLINK    = 8'h03;
    localparam logic [7:0] DIG_BASE_DEF  = 8'h10;

    localparam int unsigned CTRL_SCAN_EN = 0;
    localparam int unsigned CTRL_SEG_POL = 1;
    localparam int unsigned CTRL_DIG_POL = 2;
    localparam int unsigned CTRL_W       = 3;

    localparam int unsigned STATUS_FRAME_BIT = 8;

    localparam int unsigned BLINK_MASK_LSB = 0;
    localparam int unsigned BLINK_MASK_MSB = 15;
    localparam int unsigned BLINK_DIV_LSB  = 16;
    localparam int unsigned BLINK_DIV_MSB  = 23;

    localparam logic [7:0] BLANK_PAT = 8'h00;

    // Ones in the low n bit positions: the blink mask bits that map to real digits.
    function automatic logic [15:0] digit_mask(input int unsigned n);
        logic [15:0] m;
        m = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/lcd_seg_scan.sv
// lcd_seg_scan: digit-scan engine.
//   Prescale dwell counter, digit index and frame toggle, optional blink
//   phase (LCD_SEG_BLINK_EN), and the registered, polarity-adjusted outputs.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   scan_en, seg_pol,    CTRL fields
//   dig_pol
//   prescale [15:0]      HCLOCK cycles per digit dwell (0 behaves as 1)
//   pattern  [7:0]       DIGIT[idx] from the register bank
//   blink_mask, blink_div  BLINK fields (LCD_SEG_BLINK_EN only)
//   idx [3:0], frame     current digit index, frame toggle
//   seg_out [7:0]        segment pattern after polarity
//   dig_sel [N-1:0]      one-hot digit enable after polarity
module lcd_seg_scan
    import lcd_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_en,
    input  logic                  seg_pol,
    input  logic                  dig_pol,
    input  logic [15:0]           prescale,
    input  logic [7:0]            pattern,
`ifdef LCD_SEG_BLINK_EN
    input  logic [15:0]           blink_mask,
    input  logic [7:0]            blink_div,
`endif
    output logic [3:0]            idx,
    output logic                  frame,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_sel
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_DIGITS - 1);

    logic [15:0]           cnt;
    logic                  reload;
    logic                  wrap;
    logic [7:0]            shown;
    logic [NUM_DIGITS-1:0] onehot;

`ifdef LCD_SEG_BLINK_EN
    logic [7:0] fcnt;
    logic       blink_ph;
`endif

    always_comb begin
        // cnt<=1 also covers PRESCALE==0, which then advances every cycle
        reload = (cnt <= 16'd1);
        wrap   = reload && (idx == LAST_IDX);
        shown  = pattern;
`ifdef LCD_SEG_BLINK_EN
        if (blink_ph && blink_mask[idx]) begin
            shown = BLANK_PAT;
        end
`endif
        onehot = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            onehot[i] = (idx == 4'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            frame   <= 1'b0;
            seg_out <= '0;
            dig_sel <= '0;
        end else if (!scan_en) begin
            cnt     <= prescale;
            idx     <= '0;
            seg_out <= {8{seg_pol}};
            dig_sel <= {NUM_DIGITS{dig_pol}};
        end else begin
            seg_out <= shown ^ {8{seg_pol}};
            dig_sel <= onehot ^ {NUM_DIGITS{dig_pol}};
            if (reload) begin
                cnt <= prescale;
                idx <= wrap ? 4'd0 : idx + 4'd1;
                if (wrap) begin
                    frame <= ~frame;
                end
            end else begin
                cnt <= cnt - 16'd1;
            end
        end
    end

`ifdef LCD_SEG_BLINK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt     <= '0;
            blink_ph <= 1'b0;
        end else if (!scan_en || blink_div == 8'd0) begin
            fcnt     <= '0;
            blink_ph <= 1'b0;
        end else if (wrap) begin
            // >= keeps the counter bounded if DIV is lowered below the current count
            if (fcnt + 8'd1 >= blink_div) begin
                fcnt     <= '0;
                blink_ph <= ~blink_ph;
            end else begin
                fcnt <= fcnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/lcd_seg_regfile.sv
// lcd_seg_regfile: register bank and digit-scan top for the LCD/7-segment glass.
//   Sits behind the AHB slave state machine: write on enable==0, registered
//   read data with one-cycle latency. Optional blink feature: LCD_SEG_BLINK_EN.
// Ports:
//   HCLOCK, HRESETn      clock, asynchronous active-low reset
//   enable               write strobe, active low
//   write                HWRITE pass-through (not used to qualify anything)
//   slave_address [9:2]  word address
//   data [31:0]          write data
//   HRDATA [31:0]        registered read data
//   seg_out [7:0]        segment pattern {dp,g,f,e,d,c,b,a}
//   dig_sel [N-1:0]      digit enables
module lcd_seg_regfile
    import lcd_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter logic [7:0]  DIG_BASE     = DIG_BASE_DEF,
    parameter logic [15:0] PRESCALE_RST = 16'd1000
) (
    input  logic                  HCLOCK,
    input  logic                  HRESETn,
    input  logic                  enable,
    input  logic                  write,
    input  logic [9:2]            slave_address,
    input  logic [31:0]           data,
    output logic [31:0]           HRDATA,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_sel
);

    logic [CTRL_W-1:0] ctrl;
    logic [15:0]       prescale;
    logic [7:0]        digit [NUM_DIGITS];
    logic [7:0]        dig_off;
    logic              dig_hit;
    logic [7:0]        pattern;
    logic [3:0]        idx;
    logic              frame;
    logic [31:0]       rd_mux;
    logic              unused_in;

`ifdef LCD_SEG_BLINK_EN
    localparam logic [15:0] MASK_VALID = digit_mask(NUM_DIGITS);
    logic [15:0] blink_mask;
    logic [7:0]  blink_div;
`endif

    // write qualifies nothing; upper data bits are ignored by every register
    assign unused_in = ^{write, data};

    always_comb begin
        dig_off = slave_address - DIG_BASE;
        dig_hit = (slave_address >= DIG_BASE) && (dig_off < 8'(NUM_DIGITS));
    end

    always_ff @(posedge HCLOCK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl     <= '0;
            prescale <= PRESCALE_RST;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                digit[i] <= '0;
            end
`ifdef LCD_SEG_BLINK_EN
            blink_mask <= '0;
            blink_div  <= '0;
`endif
        end else if (!enable) begin
            if (slave_address == ADDR_CTRL) begin
                ctrl <= data[CTRL_W-1:0];
            end
            if (slave_address == ADDR_PRESCALE) begin
                prescale <= data[15:0];
            end
`ifdef LCD_SEG_BLINK_EN
            if (slave_address == ADDR_BLINK) begin
                blink_mask <= data[BLINK_MASK_MSB:BLINK_MASK_LSB] & MASK_VALID;
                blink_div  <= data[BLINK_DIV_MSB:BLINK_DIV_LSB];
            end
`endif
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (dig_hit && dig_off == 8'(i)) begin
                    digit[i] <= data[7:0];
                end
            end
        end
    end

    always_comb begin
        pattern = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 4'(i)) begin
                pattern = digit[i];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (slave_address)
            ADDR_CTRL:     rd_mux[CTRL_W-1:0] = ctrl;
            ADDR_PRESCALE: rd_mux[15:0] = prescale;
            ADDR_STATUS: begin
                rd_mux[3:0]              = idx;
                rd_mux[STATUS_FRAME_BIT] = frame;
            end
`ifdef LCD_SEG_BLINK_EN
            ADDR_BLINK: begin
                rd_mux[BLINK_MASK_MSB:BLINK_MASK_LSB] = blink_mask;
                rd_mux[BLINK_DIV_MSB:BLINK_DIV_LSB]   = blink_div;
            end
`endif
            default: ;
        endcase
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (dig_hit && dig_off == 8'(i)) begin
                rd_mux[7:0] = digit[i];
            end
        end
    end

    // Sampled on the same edge as a write, so a same-cycle read returns the old value
    always_ff @(posedge HCLOCK or negedge HRESETn) begin
        if (!HRESETn) begin
            HRDATA <= '0;
        end else begin
            HRDATA <= rd_mux;
        end
    end

    lcd_seg_scan #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_scan (
        .clk       (HCLOCK),
        .rst_n     (HRESETn),
        .scan_en   (ctrl[CTRL_SCAN_EN]),
        .seg_pol   (ctrl[CTRL_SEG_POL]),
        .dig_pol   (ctrl[CTRL_DIG_POL]),
        .prescale  (prescale),
        .pattern   (pattern),
`ifdef LCD_SEG_BLINK_EN
        .blink_mask(blink_mask),
        .blink_div (blink_div),
`endif
        .idx       (idx),
        .frame     (frame),
        .seg_out   (seg_out),
        .dig_sel   (dig_sel)
    );

endmodule
